// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: IN_W-bit immediate + mode -> OUT_W-bit operand,
// with a valid/ready handshake and a 2-entry skid buffer so in_ready is registered.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: a beat moves on a port when valid & ready are both high at the
  // rising edge; valid never waits on ready, and payload holds while valid & !ready.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SEXT  = 2'b00;
  localparam logic [1:0] MODE_ZEXT  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  state_t           state_q;
  state_t           state_d;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] skid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] ext_val;
  logic [OUT_W-1:0] sext_val;
  logic             accept;
  logic             xfer;
  logic             load_out_ext;
  logic             load_out_skid;
  logic             load_skid;

  // Extension of the immediate currently on the input port
  always_comb begin
    sext_val = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    ext_val  = sext_val;
    unique case (in_mode)
      MODE_SEXT:   ext_val = sext_val;
      MODE_ZEXT:   ext_val = {{(OUT_W-IN_W){1'b0}}, in_imm};
      MODE_UPPER:  ext_val = {in_imm, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: ext_val = sext_val << 2;
      default:     ext_val = sext_val;
    endcase
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_q;
  assign xfer_cnt  = cnt_q;
  assign dbg_state = state_q;

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  always_comb begin
    state_d       = state_q;
    load_out_ext  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          load_out_ext = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          load_out_ext = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the skid drain can happen
        if (xfer) begin
          load_out_skid = 1'b1;
          state_d       = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_out_ext) begin
        out_q <= ext_val;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= ext_val;
      end
      if (xfer) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: vector table, backpressure, streaming, counter wrap
// and mid-operation reset, with an ordered expected-result queue on the output.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  xfer_cnt;
  logic [1:0]  dbg_state;

  logic        in_valid2;
  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_data2;
  logic [1:0]  xfer_cnt2;
  logic [1:0]  dbg_state2;

  logic [31:0] exp_q[$];
  int          n_cmp;
  int          n_err;

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_cnt(xfer_cnt), .dbg_state(dbg_state)
  );

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_imm(16'h0000), .in_mode(2'b00),
    .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2),
    .xfer_cnt(xfer_cnt2), .dbg_state(dbg_state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
    logic signed [31:0] s;
    s = 32'($signed(imm));
    case (mode)
      2'd0:    return s;
      2'd1:    return {16'h0000, imm};
      2'd2:    return {imm, 16'h0000};
      default: return s * 4;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: push on accept, pop and compare on output transfer
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_data, 32'hxxxxxxxx);
        end else begin
          check("sb_out_data", out_data, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_imm, in_mode));
    end
  end

  initial begin
    logic [1:0] wrap_exp[5];
    n_cmp = 0;
    n_err = 0;
    tbl[0] = '{16'hFF88, 2'b00, 32'hFFFFFF88};
    tbl[1] = '{16'hFF88, 2'b01, 32'h0000FF88};
    tbl[2] = '{16'hFF88, 2'b10, 32'hFF880000};
    tbl[3] = '{16'hFF88, 2'b11, 32'hFFFFFE20};
    tbl[4] = '{16'h0020, 2'b00, 32'h00000020};
    tbl[5] = '{16'h0080, 2'b11, 32'h00000200};
    tbl[6] = '{16'h7FFF, 2'b00, 32'h00007FFF};
    tbl[7] = '{16'h0000, 2'b10, 32'h00000000};
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    rst_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
    in_valid2 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", out_data, 32'd0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // vector table, one result per cycle, each visible right after its accept edge
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_imm = tbl[i].imm; in_mode = tbl[i].mode;
      tick();
      check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("tbl%0d_data", i), out_data, tbl[i].exp);
      if (i == 3) begin
        in_valid = 1'b0;
        tick();
        check("sweep_xfer_cnt", 32'(xfer_cnt), 32'd4);
      end
    end
    in_valid = 1'b0;
    tick();
    check("table_xfer_cnt", 32'(xfer_cnt), 32'd8);

    // backpressure: two accepted, third held while stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'b00; in_imm = 16'h0001;
    @(negedge clk); check("bp_accept1_ready", 32'(in_ready), 32'd1);
    tick(); in_imm = 16'h0002;
    @(negedge clk); check("bp_accept2_ready", 32'(in_ready), 32'd1);
    tick(); in_imm = 16'h0003;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_full_ready", 32'(in_ready), 32'd0);
      check("bp_stable_data", out_data, 32'h00000001);
      check("bp_stable_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk); check("bp_release_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("bp_ready_back", 32'(in_ready), 32'd1);
    check("bp_second", out_data, 32'h00000002);
    tick();
    in_valid = 1'b0;
    check("bp_third", out_data, 32'h00000003);
    tick();
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_xfer_cnt", 32'(xfer_cnt), 32'd11);

    // reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h1234; in_mode = 2'b01;
    tick(); tick();
    in_valid = 1'b0;
    check("mid_full_state", 32'(dbg_state), 32'd2);
    check("mid_full_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_imm = 16'h8000; in_mode = 2'b00;
    tick();
    in_valid = 1'b0;
    check("post_rst_data", out_data, 32'hFFFF8000);
    tick();
    check("post_rst_no_stale", 32'(out_valid), 32'd0);
    check("post_rst_cnt", 32'(xfer_cnt), 32'd1);

    // streaming from a clean counter
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_imm = 16'($urandom_range(0, 65535));
      in_mode = 2'($urandom_range(0, 3));
      @(negedge clk); check("stream_ready", 32'(in_ready), 32'd1);
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_cnt", 32'(xfer_cnt), 32'd20);
    check("stream_idle", 32'(out_valid), 32'd0);

    // counter wrap on the 2-bit instance
    in_valid2 = 1'b1;
    tick();
    check("w2_ready", 32'(in_ready2), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("w2_cnt%0d", k), 32'(xfer_cnt2), 32'(wrap_exp[k]));
      check("w2_valid", 32'(out_valid2), 32'd1);
      check("w2_data", out_data2, 32'd0);
    end
    in_valid2 = 1'b0;
    tick();
    check("w2_cnt_final", 32'(xfer_cnt2), 32'd2);
    check("w2_state", 32'(dbg_state2), 32'd0);

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate extender: the successor to the combinational 16→32 sign extender.
- Takes an IN_W-bit instruction immediate plus a mode code and produces an OUT_W-bit operand in one of four modes.
- Sits between the decode stage and the ALU operand mux, with a valid/ready handshake.
- A 2-entry skid buffer lets decode keep issuing while execute stalls, with no combinational ready path.

Parameters:
- IN_W, 16, immediate input width.
- OUT_W, 32, extended output width; must satisfy OUT_W >= IN_W+2.
- CNT_W, 8, width of the completed-transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream has an immediate.
- in_ready  output  1  block can accept an immediate this cycle.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  00 sign-ext, 01 zero-ext, 10 upper (LUI), 11 branch offset.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  OUT_W  extended result.
- xfer_cnt  output  CNT_W  count of completed output handshakes.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-low: a rising clk edge with rst_n=0 clears all state.
  - Reset values: out_valid=0, out_data=0, xfer_cnt=0, skid register empty and its data 0, state EMPTY, in_ready=1.
  - No handshake completes on a reset edge; data in flight is discarded.
- Extension, evaluated on in_imm at acceptance:
  - 00: replicate in_imm[IN_W-1] into bits OUT_W-1..IN_W.
  - 01: zero-fill bits OUT_W-1..IN_W.
  - 10: in_imm placed at bits OUT_W-1..OUT_W-IN_W; lower bits zero.
  - 11: sign-extend, then shift left 2. Bits shifted out of OUT_W are dropped; the low 2 bits are 0.
- Handshake:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - in_valid may be held; in_imm/in_mode are sampled only on accept.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- Timing:
  - in_ready is a pure function of registered state: it is 0 only in FULL and never depends on out_ready or in_valid.
  - Latency: accept at edge N → out_valid=1 with the result after edge N, when the pipe was EMPTY or draining.
  - Throughput is 1 per cycle with out_ready held 1.
- States:
  - EMPTY: out_valid=0.
  - ONE: out register full, skid empty.
  - FULL: both full, in_ready=0.
- Transitions:
  - EMPTY + accept → ONE; the result loads into the out register.
  - ONE + accept + transfer → ONE; the new result replaces the out register.
  - ONE + accept, no transfer → FULL; the result goes to skid.
  - ONE + transfer, no accept → EMPTY.
  - ONE, neither → ONE.
  - FULL + transfer → ONE; skid moves to the out register. No accept is possible in FULL.
  - FULL, no transfer → FULL.
- Order: results leave in strict acceptance order; no drops, no duplicates.
- xfer_cnt: +1 on every output transfer; wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: contents of both the out and skid registers are lost. The first accept after release behaves as from EMPTY.

Test Plan:
Defaults IN_W=16, OUT_W=32 throughout.
- Mode sweep, out_ready=1, in_imm=0xFF88 in each mode → 00:0xFFFFFF88, 01:0x0000FF88, 10:0xFF880000, 11:0xFFFFFE20; each appears one cycle after accept; xfer_cnt ends at 4.
- Positive values, out_ready=1:
  - 0x0020/00 → 0x00000020.
  - 0x0080/11 → 0x00000200.
  - 0x7FFF/00 → 0x00007FFF.
  - 0x0000/10 → 0x00000000.
- Backpressure:
  - Setup: out_ready=0; offer 0x0001, 0x0002, 0x0003, all mode 00.
  - While stalled: the first two are accepted, then in_ready=0 with 0x0003 held and out_data stable at 0x00000001.
  - Release: raise out_ready; outputs are 0x1, 0x2, 0x3 in order, and in_ready returns to 1 the cycle after the first transfer.
- Streaming: 20 back-to-back inputs, out_ready=1 → one output per cycle, in_ready always 1, xfer_cnt=20.
- Counter wrap: with CNT_W=2, 5 transfers → xfer_cnt sequence 1, 2, 3, 0, 1.
- Reset mid-operation:
  - Reach FULL, then pulse rst_n=0 for one edge → out_valid=0, in_ready=1, xfer_cnt=0.
  - Next accept of 0x8000/00 → 0xFFFF8000, with no stale data emitted.
